// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - op encodings and width/bound helpers for the SIMD add/sub lane array
package simd_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  function automatic int res_width(input int w);
    return w + 1;
  endfunction

  // Bounds of a signed (w+1)-bit result.
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << w);
  endfunction

endpackage

// File: rtl/simd_addsub_lane_array_lane.sv
// rtl/simd_addsub_lane_array_lane.sv - one lane: S2 arithmetic, accumulator, clamp/wrap and ovf
module simd_lane
  import simd_pkg::*;
#(
  parameter int W   = 12,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load_i,
  input  logic         en_i,
  input  op_e          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   out_o,
  output logic         ovf_o
);

  localparam int RW = res_width(W);
  localparam logic [RW-1:0] MAX_V = RW'(sat_max(W));
  localparam logic [RW-1:0] MIN_V = RW'(sat_min(W));

  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] out_q, out_d;
  logic          ovf_q, ovf_d;
  logic [RW-1:0] sum_w, dif_w;
  logic [RW:0]   tot_w;
  logic          tot_ovf;

  assign sum_w   = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  assign dif_w   = {a_i[W-1], a_i} - {b_i[W-1], b_i};
  assign tot_w   = {acc_q[RW-1], acc_q} + {sum_w[RW-1], sum_w};
  // The W+2-bit total fits in W+1 bits only when its top two bits agree.
  assign tot_ovf = tot_w[RW] ^ tot_w[RW-1];

  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    ovf_d = ovf_q;
    if (load_i) begin
      out_d = '0;
      ovf_d = 1'b0;
      if (en_i) begin
        case (op_i)
          OP_ADD:  out_d = sum_w;
          OP_SUB:  out_d = dif_w;
          OP_LOAD: begin
            out_d = sum_w;
            acc_d = sum_w;
          end
          default: begin
            if (tot_ovf) begin
              ovf_d = 1'b1;
              out_d = SAT ? (tot_w[RW] ? MIN_V : MAX_V) : tot_w[RW-1:0];
            end else begin
              out_d = tot_w[RW-1:0];
            end
            acc_d = out_d;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_o = out_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/simd_addsub_lane_array.sv
// rtl/simd_addsub_lane_array.sv - N-lane two-stage add/sub/accumulate unit with valid/ready
module simd_addsub_lane_array
  import simd_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 12,
  parameter bit SAT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [N-1:0]       lane_en,
  input  logic [N*W-1:0]     a,
  input  logic [N*W-1:0]     b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*(W+1)-1:0] out,
  output logic [N-1:0]       ovf
);

  localparam int RW = res_width(W);

  logic           s1_valid_q, s1_valid_d;
  op_e            op_q, op_d;
  logic [N-1:0]   en_q, en_d;
  logic [N*W-1:0] a_q, a_d;
  logic [N*W-1:0] b_q, b_d;
  logic           out_valid_q, out_valid_d;
  logic           advance;
  logic           accept;
  logic           lane_load;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = !clr && (!s1_valid_q || advance);
  assign accept    = in_valid && in_ready;
  assign lane_load = s1_valid_q && advance && !clr;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    op_d        = op_q;
    en_d        = en_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      s1_valid_d  = 1'b0;
      op_d        = OP_ADD;
      en_d        = '0;
      a_d         = '0;
      b_d         = '0;
      out_valid_d = 1'b0;
    end else begin
      if (advance) begin
        out_valid_d = s1_valid_q;
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        op_d       = op_e'(op);
        en_d       = lane_en;
        a_d        = a;
        b_d        = b;
      end else if (advance) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      op_q        <= OP_ADD;
      en_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      op_q        <= op_d;
      en_q        <= en_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar g = 0; g < N; g++) begin : g_lane
    simd_lane #(
      .W   (W),
      .SAT (SAT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .load_i (lane_load),
      .en_i   (en_q[g]),
      .op_i   (op_q),
      .a_i    (a_q[g*W +: W]),
      .b_i    (b_q[g*W +: W]),
      .out_o  (out[g*RW +: RW]),
      .ovf_o  (ovf[g])
    );
  end

endmodule

// File: tb/tb_simd_addsub_lane_array.sv
// tb/tb_simd_addsub_lane_array.sv - directed bench for simd_addsub_lane_array (SAT=1 and SAT=0)
module tb_simd_addsub_lane_array;
  import simd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  lane_en = 4'h0;
  logic [47:0] a = '0;
  logic [47:0] b = '0;
  logic        out_ready = 1'b1;
  logic        in_ready_s, in_ready_w, out_valid_s, out_valid_w;
  logic [51:0] out_s, out_w;
  logic [3:0]  ovf_s, ovf_w;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  simd_addsub_lane_array #(.N(4), .W(12), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .lane_en(lane_en), .a(a), .b(b), .out_valid(out_valid_s),
    .out_ready(out_ready), .out(out_s), .ovf(ovf_s)
  );

  simd_addsub_lane_array #(.N(4), .W(12), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
    .op(op), .lane_en(lane_en), .a(a), .b(b), .out_valid(out_valid_w),
    .out_ready(out_ready), .out(out_w), .ovf(ovf_w)
  );

  function automatic logic [47:0] pack(input int v0, input int v1, input int v2, input int v3);
    return {12'(v3), 12'(v2), 12'(v1), 12'(v0)};
  endfunction

  function automatic logic signed [12:0] lane13(input logic [51:0] v, input int l);
    return v[l*13 +: 13];
  endfunction

  task automatic drive(input op_e o, input logic [3:0] en, input logic [47:0] av, input logic [47:0] bv);
    in_valid = 1'b1;
    op       = o;
    lane_en  = en;
    a        = av;
    b        = bv;
  endtask

  // Offers one beat and returns at the negedge where its result is presented.
  task automatic run_beat(input op_e o, input logic [3:0] en, input logic [47:0] av, input logic [47:0] bv);
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(o, en, av, bv);
    n = 0;
    @(negedge clk);
    while (!in_ready_s && n < 8) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid_s && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid_s) begin
      errors++;
      $display("FAIL beat_timeout: out_valid=%0b required 1", out_valid_s);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %0b/%0b required 0", out_valid_s, out_valid_w);
    end
    checks++;
    if (out_s !== 52'd0 || ovf_s !== 4'd0 || out_w !== 52'd0 || ovf_w !== 4'd0) begin
      errors++; $display("FAIL reset_out: got %h/%h required 0", out_s, ovf_s);
    end
    checks++;
    if (in_ready_s !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    int exp_v [4] = '{123, -10, 4094, -4096};
    @(posedge clk); #1;
    drive(OP_ADD, 4'hf, pack(100, -5, 2047, -2048), pack(23, -5, 2047, -2048));
    @(negedge clk);
    checks++;
    if (in_ready_s !== 1'b1) begin
      errors++; $display("FAIL add_in_ready: got %0b required 1", in_ready_s);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_s !== 1'b0) begin
      errors++; $display("FAIL add_latency_early: out_valid=%0b required 0", out_valid_s);
    end
    @(negedge clk);
    checks++;
    if (out_valid_s !== 1'b1) begin
      errors++; $display("FAIL add_latency: out_valid=%0b required 1", out_valid_s);
    end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (lane13(out_s, l) !== 13'(exp_v[l]) || lane13(out_w, l) !== 13'(exp_v[l])) begin
        errors++; $display("FAIL add_lane%0d: got %0d/%0d required %0d", l, lane13(out_s, l), lane13(out_w, l), exp_v[l]);
      end
    end
    checks++;
    if (ovf_s !== 4'd0 || ovf_w !== 4'd0) begin
      errors++; $display("FAIL add_ovf: got %b/%b required 0000", ovf_s, ovf_w);
    end
  endtask

  task automatic test_sub();
    int exp_v [4] = '{-1, 0, -4095, 0};
    run_beat(OP_SUB, 4'b0101, pack(0, 7, -2048, 9), pack(1, 3, 2047, 9));
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (lane13(out_s, l) !== 13'(exp_v[l]) || lane13(out_w, l) !== 13'(exp_v[l])) begin
        errors++; $display("FAIL sub_lane%0d: got %0d/%0d required %0d", l, lane13(out_s, l), lane13(out_w, l), exp_v[l]);
      end
    end
  endtask

  task automatic test_sat_wrap();
    int ex_s1 [4] = '{4095, 4095, 0, -4096};
    int ex_w1 [4] = '{-3992, 4095, 0, 4095};
    int ex_s2 [4] = '{4095, 4095, 4000, -4096};
    int ex_w2 [4] = '{-3992, 4095, 4000, 4095};
    run_beat(OP_LOAD, 4'hf, pack(2000, 2000, 2000, -2048), pack(2000, 2000, 2000, -2048));
    checks++;
    if (lane13(out_s, 0) !== 13'(4000) || lane13(out_w, 3) !== 13'(-4096) || ovf_s !== 4'd0) begin
      errors++; $display("FAIL load: got %0d/%0d ovf %b required 4000/-4096 ovf 0000", lane13(out_s, 0), lane13(out_w, 3), ovf_s);
    end
    run_beat(OP_ACC, 4'b1011, pack(100, 95, 1000, -1), pack(100, 0, 1000, 0));
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (lane13(out_s, l) !== 13'(ex_s1[l]) || lane13(out_w, l) !== 13'(ex_w1[l])) begin
        errors++; $display("FAIL acc_ovf_lane%0d: got %0d/%0d required %0d/%0d", l, lane13(out_s, l), lane13(out_w, l), ex_s1[l], ex_w1[l]);
      end
    end
    checks++;
    if (ovf_s !== 4'b1001 || ovf_w !== 4'b1001) begin
      errors++; $display("FAIL acc_ovf_flags: got %b/%b required 1001", ovf_s, ovf_w);
    end
    run_beat(OP_ACC, 4'hf, '0, '0);
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (lane13(out_s, l) !== 13'(ex_s2[l]) || lane13(out_w, l) !== 13'(ex_w2[l])) begin
        errors++; $display("FAIL acc_hold_lane%0d: got %0d/%0d required %0d/%0d", l, lane13(out_s, l), lane13(out_w, l), ex_s2[l], ex_w2[l]);
      end
    end
    checks++;
    if (ovf_s !== 4'd0 || ovf_w !== 4'd0) begin
      errors++; $display("FAIL acc_hold_flags: got %b/%b required 0000", ovf_s, ovf_w);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    int it = 0;
    bit saw_low = 1'b0;
    int rcv_it [8];
    run_beat(OP_LOAD, 4'hf, '0, '0);
    while (recv < 8 && it < 40) begin
      @(posedge clk); #1;
      out_ready = !(it >= 4 && it <= 6);
      if (sent < 8) drive(OP_ACC, 4'hf, pack(1, 1, 1, 1), '0);
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready_s) sent++;
      if (it >= 4 && it <= 6 && !in_ready_s) saw_low = 1'b1;
      if (out_valid_s) begin
        checks++;
        if (lane13(out_s, 0) !== 13'(recv + 1) || lane13(out_w, 3) !== 13'(recv + 1)) begin
          errors++; $display("FAIL stream_value: got %0d/%0d required %0d", lane13(out_s, 0), lane13(out_w, 3), recv + 1);
        end
        if (out_ready) begin
          rcv_it[recv] = it;
          recv++;
        end
      end
      it++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 8) begin
      errors++; $display("FAIL stream_count: got %0d required 8", recv);
    end else begin
      checks++;
      if (rcv_it[0] != 2 || rcv_it[1] != 3 || rcv_it[2] != 7 || rcv_it[7] != 12) begin
        errors++; $display("FAIL stream_timing: got %0d,%0d,%0d,%0d required 2,3,7,12", rcv_it[0], rcv_it[1], rcv_it[2], rcv_it[7]);
      end
    end
    checks++;
    if (!saw_low) begin
      errors++; $display("FAIL stall_in_ready: in_ready never 0 during stall, required 0");
    end
    run_beat(OP_ACC, 4'hf, '0, '0);
    checks++;
    if (lane13(out_s, 0) !== 13'(8) || lane13(out_w, 2) !== 13'(8)) begin
      errors++; $display("FAIL stream_final_acc: got %0d/%0d required 8", lane13(out_s, 0), lane13(out_w, 2));
    end
  endtask

  task automatic test_clr();
    int xfers = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(OP_ACC, 4'hf, pack(3, 3, 3, 3), '0);
    @(posedge clk); #1;
    drive(OP_ACC, 4'hf, pack(4, 4, 4, 4), '0);
    @(posedge clk); #1;
    clr = 1'b1;
    drive(OP_ACC, 4'hf, pack(9, 9, 9, 9), '0);
    @(negedge clk);
    checks++;
    if (in_ready_s !== 1'b0) begin
      errors++; $display("FAIL clr_in_ready_full: got %0b required 0", in_ready_s);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_s !== 1'b0 || in_ready_w !== 1'b0) begin
      errors++; $display("FAIL clr_in_ready_empty: got %0b/%0b required 0", in_ready_s, in_ready_w);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid_s || out_valid_w) xfers++;
    end
    checks++;
    if (xfers != 0) begin
      errors++; $display("FAIL clr_flush: got %0d results required 0", xfers);
    end
    run_beat(OP_ACC, 4'hf, pack(5, 5, 5, 5), '0);
    checks++;
    if (lane13(out_s, 0) !== 13'(5) || lane13(out_w, 1) !== 13'(5)) begin
      errors++; $display("FAIL clr_acc: got %0d/%0d required 5", lane13(out_s, 0), lane13(out_w, 1));
    end
  endtask

  task automatic test_async_rst();
    run_beat(OP_LOAD, 4'hf, pack(50, 50, 50, 50), pack(50, 50, 50, 50));
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0 || out_s !== 52'd0 || ovf_s !== 4'd0 || out_w !== 52'd0) begin
      errors++; $display("FAIL async_rst: got valid %0b out %h required 0", out_valid_s, out_s);
    end
    #1 rst = 1'b0;
    run_beat(OP_ACC, 4'hf, pack(7, 7, 7, 7), '0);
    checks++;
    if (lane13(out_s, 0) !== 13'(7) || lane13(out_w, 3) !== 13'(7)) begin
      errors++; $display("FAIL rst_acc: got %0d/%0d required 7", lane13(out_s, 0), lane13(out_w, 3));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_sat_wrap();
    test_back_to_back();
    test_clr();
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
